// File: rtl/ppu_bg_shifter.sv
// Background pixel pipeline: captures fetch results from the upstream fetch FSM,
// reloads the pattern/attribute shifters at tile boundaries and emits one pixel per dot.
module ppu_bg_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bg_state,
    input  logic       data_valid,
    input  logic [7:0] vram_data,
    input  logic [1:0] at_quad,
    input  logic       shift_en,
    input  logic [2:0] fine_x,
    input  logic [7:0] pixel_x,
    input  logic       bg_enable,
    input  logic       show_left8,
    output logic [7:0] nt_byte,
    output logic [3:0] bg_pixel,
    output logic       bg_opaque,
    output logic       pixel_valid
);

    localparam logic [2:0] ST_SLEEP  = 3'b000;
    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_NT     = 3'b010;
    localparam logic [2:0] ST_AT     = 3'b011;
    localparam logic [2:0] ST_BG_LSB = 3'b100;
    localparam logic [2:0] ST_BG_MSB = 3'b101;
    localparam logic [2:0] ST_VBLANK = 3'b110;

    logic [2:0]  prev_state;
    logic [1:0]  at_latch_next;
    logic [1:0]  at_latch;
    logic [7:0]  pt_lo_latch;
    logic [7:0]  pt_hi_latch;
    logic [15:0] pt_lo_sh;
    logic [15:0] pt_hi_sh;
    logic [7:0]  at_lo_sh;
    logic [7:0]  at_hi_sh;

    logic        reload;
    logic [1:0]  at_sel;
    logic [15:0] pt_lo_next;
    logic [15:0] pt_hi_next;
    logic [7:0]  at_lo_next;
    logic [7:0]  at_hi_next;
    logic [3:0]  pt_idx;
    logic [2:0]  at_idx;
    logic [1:0]  pix_pattern;
    logic [1:0]  pix_palette;
    logic        clip;

    // A tile boundary is the cycle the fetch FSM leaves BG_MSB.
    assign reload = (prev_state == ST_BG_MSB) && (bg_state != ST_BG_MSB);

    always_comb begin
        at_sel = 2'b00;
        case (at_quad)
            2'd0: at_sel = vram_data[1:0];
            2'd1: at_sel = vram_data[3:2];
            2'd2: at_sel = vram_data[5:4];
            default: at_sel = vram_data[7:6];
        endcase
    end

    // Reload overwrites only the low byte, so a coincident shift still advances the high byte.
    always_comb begin
        pt_lo_next = shift_en ? {pt_lo_sh[14:0], 1'b0} : pt_lo_sh;
        pt_hi_next = shift_en ? {pt_hi_sh[14:0], 1'b0} : pt_hi_sh;
        if (reload) begin
            pt_lo_next[7:0] = pt_lo_latch;
            pt_hi_next[7:0] = pt_hi_latch;
        end
        at_lo_next = shift_en ? {at_lo_sh[6:0], at_latch[0]} : at_lo_sh;
        at_hi_next = shift_en ? {at_hi_sh[6:0], at_latch[1]} : at_hi_sh;
    end

    assign pt_idx      = 4'd15 - {1'b0, fine_x};
    assign at_idx      = 3'd7 - fine_x;
    assign pix_pattern = {pt_hi_sh[pt_idx], pt_lo_sh[pt_idx]};
    assign pix_palette = {at_hi_sh[at_idx], at_lo_sh[at_idx]};
    assign clip        = !bg_enable || ((pixel_x < 8'd8) && !show_left8);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state    <= ST_SLEEP;
            nt_byte       <= 8'h00;
            at_latch_next <= 2'b00;
            at_latch      <= 2'b00;
            pt_lo_latch   <= 8'h00;
            pt_hi_latch   <= 8'h00;
            pt_lo_sh      <= 16'h0000;
            pt_hi_sh      <= 16'h0000;
            at_lo_sh      <= 8'h00;
            at_hi_sh      <= 8'h00;
            bg_pixel      <= 4'h0;
            bg_opaque     <= 1'b0;
            pixel_valid   <= 1'b0;
        end else begin
            prev_state <= bg_state;
            if (data_valid) begin
                case (bg_state)
                    ST_NT:     nt_byte       <= vram_data;
                    ST_AT:     at_latch_next <= at_sel;
                    ST_BG_LSB: pt_lo_latch   <= vram_data;
                    ST_BG_MSB: pt_hi_latch   <= vram_data;
                    ST_SLEEP, ST_IDLE, ST_VBLANK: ;
                    default: ;
                endcase
            end
            pt_lo_sh <= pt_lo_next;
            pt_hi_sh <= pt_hi_next;
            at_lo_sh <= at_lo_next;
            at_hi_sh <= at_hi_next;
            if (reload) begin
                at_latch <= at_latch_next;
            end
            if (shift_en) begin
                pixel_valid <= 1'b1;
                bg_pixel    <= clip ? 4'h0 : {pix_palette, pix_pattern};
                bg_opaque   <= !clip && (pix_pattern != 2'b00);
            end else begin
                pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_bg_shifter.sv
// Self-checking bench for ppu_bg_shifter: directed tile scenarios plus randomized
// traffic compared against an arithmetic reference model of the pixel pipeline.
module tb_ppu_bg_shifter;

    localparam logic [2:0] S_SLEEP  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_NT     = 3'd2;
    localparam logic [2:0] S_AT     = 3'd3;
    localparam logic [2:0] S_LSB    = 3'd4;
    localparam logic [2:0] S_MSB    = 3'd5;
    localparam logic [2:0] S_VBLANK = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] bg_state = S_SLEEP;
    logic       data_valid = 1'b0;
    logic [7:0] vram_data = 8'h00;
    logic [1:0] at_quad = 2'd0;
    logic       shift_en = 1'b0;
    logic [2:0] fine_x = 3'd0;
    logic [7:0] pixel_x = 8'd100;
    logic       bg_enable = 1'b1;
    logic       show_left8 = 1'b1;
    logic [7:0] nt_byte;
    logic [3:0] bg_pixel;
    logic       bg_opaque;
    logic       pixel_valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: shifters kept as plain integers
    int         m_prev, m_atn, m_at, m_plo, m_phi;
    int         m_plo_sh, m_phi_sh, m_alo_sh, m_ahi_sh;
    logic [7:0] m_nt;
    logic [3:0] m_pix;
    logic       m_opq, m_val;

    logic [3:0] exp_tile [8] = '{4'hB, 4'hA, 4'hB, 4'hA, 4'h9, 4'h8, 4'h9, 4'h8};
    logic [3:0] exp_fine [8] = '{4'hA, 4'h9, 4'h8, 4'h9, 4'h8, 4'h4, 4'h4, 4'h6};

    ppu_bg_shifter dut (
        .clk(clk), .rst(rst), .bg_state(bg_state), .data_valid(data_valid),
        .vram_data(vram_data), .at_quad(at_quad), .shift_en(shift_en),
        .fine_x(fine_x), .pixel_x(pixel_x), .bg_enable(bg_enable),
        .show_left8(show_left8), .nt_byte(nt_byte), .bg_pixel(bg_pixel),
        .bg_opaque(bg_opaque), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int fx, pat, pal, v;
        bit rl;
        if (rst) begin
            m_prev = 0; m_atn = 0; m_at = 0; m_plo = 0; m_phi = 0;
            m_plo_sh = 0; m_phi_sh = 0; m_alo_sh = 0; m_ahi_sh = 0;
            m_nt = 8'h00; m_pix = 4'h0; m_opq = 1'b0; m_val = 1'b0;
        end else begin
            rl = (m_prev == 5) && (int'(bg_state) != 5);
            if (shift_en) begin
                fx  = int'(fine_x);
                pat = ((m_phi_sh >> (15 - fx)) & 1) * 2 + ((m_plo_sh >> (15 - fx)) & 1);
                pal = ((m_ahi_sh >> (7 - fx)) & 1) * 2 + ((m_alo_sh >> (7 - fx)) & 1);
                if (!bg_enable || (pixel_x < 8 && !show_left8)) begin
                    m_pix = 4'h0; m_opq = 1'b0;
                end else begin
                    m_pix = 4'(pal * 4 + pat); m_opq = (pat != 0);
                end
                m_val    = 1'b1;
                m_plo_sh = (m_plo_sh * 2) % 65536;
                m_phi_sh = (m_phi_sh * 2) % 65536;
                m_alo_sh = (m_alo_sh * 2) % 256 + (m_at % 2);
                m_ahi_sh = (m_ahi_sh * 2) % 256 + (m_at / 2);
            end else begin
                m_val = 1'b0;
            end
            if (rl) begin
                m_plo_sh = (m_plo_sh / 256) * 256 + m_plo;
                m_phi_sh = (m_phi_sh / 256) * 256 + m_phi;
                m_at     = m_atn;
            end
            if (data_valid) begin
                v = int'(vram_data);
                case (int'(bg_state))
                    2: m_nt  = vram_data;
                    3: m_atn = (v >> (2 * int'(at_quad))) % 4;
                    4: m_plo = v;
                    5: m_phi = v;
                    default: ;
                endcase
            end
            m_prev = int'(bg_state);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        data_valid = 1'b0; shift_en = 1'b0; bg_state = S_SLEEP;
        bg_enable = 1'b1; show_left8 = 1'b1; pixel_x = 8'd100; fine_x = 3'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [2:0] st, input logic [7:0] d, input logic [1:0] q);
        bg_state = st; vram_data = d; at_quad = q; data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    task automatic load_tile(input logic [7:0] nt, input logic [7:0] at, input logic [1:0] q,
                             input logic [7:0] lo, input logic [7:0] hi);
        fetch(S_NT, nt, 2'd0);
        fetch(S_AT, at, q);
        fetch(S_LSB, lo, 2'd0);
        fetch(S_MSB, hi, 2'd0);
    endtask

    task automatic shift_n(input int n);
        shift_en = 1'b1;
        repeat (n) step();
        shift_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({nt_byte, bg_pixel, bg_opaque, pixel_valid} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got nt=%h pix=%h opq=%b val=%b want all 0",
                     nt_byte, bg_pixel, bg_opaque, pixel_valid);
        end
    endtask

    task automatic test_tile_decode();
        do_reset();
        load_tile(8'h24, 8'hE4, 2'd2, 8'hAA, 8'hF0);
        bg_state = S_NT; step();
        shift_n(8);
        shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (bg_pixel !== exp_tile[i] || bg_opaque !== (exp_tile[i][1:0] != 2'b00) || pixel_valid !== 1'b1) begin
                n_err++;
                $display("FAIL tile_pixel[%0d]: got pix=%h opq=%b val=%b want pix=%h opq=%b val=1",
                         i, bg_pixel, bg_opaque, pixel_valid, exp_tile[i], exp_tile[i][1:0] != 2'b00);
            end
        end
        shift_en = 1'b0;
        n_cmp++;
        if (nt_byte !== 8'h24) begin
            n_err++;
            $display("FAIL tile_nt_byte: got %h want 24", nt_byte);
        end
    endtask

    task automatic test_fine_scroll();
        do_reset();
        load_tile(8'h24, 8'hE4, 2'd2, 8'hAA, 8'hF0);
        bg_state = S_NT; step();
        load_tile(8'h11, 8'h01, 2'd0, 8'h0F, 8'h33);
        shift_n(7);
        bg_state = S_NT;
        shift_n(1);
        fine_x = 3'd3;
        shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (bg_pixel !== exp_fine[i] || pixel_valid !== 1'b1) begin
                n_err++;
                $display("FAIL fine_pixel[%0d]: got pix=%h val=%b want pix=%h val=1",
                         i, bg_pixel, pixel_valid, exp_fine[i]);
            end
        end
        shift_en = 1'b0; fine_x = 3'd0;
    endtask

    task automatic test_clipping();
        do_reset();
        load_tile(8'h24, 8'hE4, 2'd2, 8'hAA, 8'hF0);
        bg_state = S_NT; step();
        shift_n(8);
        shift_en = 1'b1; pixel_x = 8'd5; show_left8 = 1'b0;
        step();
        n_cmp++;
        if (bg_pixel !== 4'h0 || bg_opaque !== 1'b0 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clip_left: got pix=%h opq=%b val=%b want 0 0 1", bg_pixel, bg_opaque, pixel_valid);
        end
        pixel_x = 8'd8;
        step();
        n_cmp++;
        if (bg_pixel !== 4'hA || bg_opaque !== 1'b1 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clip_col8: got pix=%h opq=%b val=%b want A 1 1", bg_pixel, bg_opaque, pixel_valid);
        end
        shift_en = 1'b0;
        step();
        n_cmp++;
        if (bg_pixel !== 4'hA || bg_opaque !== 1'b1 || pixel_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_no_shift: got pix=%h opq=%b val=%b want A 1 0", bg_pixel, bg_opaque, pixel_valid);
        end
        shift_en = 1'b1; bg_enable = 1'b0; pixel_x = 8'd50;
        step();
        n_cmp++;
        if (bg_pixel !== 4'h0 || bg_opaque !== 1'b0 || pixel_valid !== 1'b1) begin
            n_err++;
            $display("FAIL clip_disabled: got pix=%h opq=%b val=%b want 0 0 1", bg_pixel, bg_opaque, pixel_valid);
        end
        shift_en = 1'b0; bg_enable = 1'b1; show_left8 = 1'b1; pixel_x = 8'd100;
    endtask

    task automatic test_shift_reload();
        logic [3:0] exp_s [3] = '{4'h1, 4'h0, 4'h1};
        logic [2:0] fx_s  [3] = '{3'd0, 3'd0, 3'd7};
        do_reset();
        load_tile(8'h00, 8'h00, 2'd0, 8'h80, 8'h00);
        bg_state = S_NT; step();
        shift_n(8);
        fetch(S_LSB, 8'hFF, 2'd0);
        fetch(S_MSB, 8'h00, 2'd0);
        bg_state = S_NT;
        shift_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fine_x = fx_s[i];
            step();
            n_cmp++;
            if (bg_pixel !== exp_s[i] || bg_pixel !== m_pix) begin
                n_err++;
                $display("FAIL shift_reload[%0d]: got pix=%h want %h (model %h)", i, bg_pixel, exp_s[i], m_pix);
            end
        end
        shift_en = 1'b0; fine_x = 3'd0;
    endtask

    task automatic test_ignored_and_reset();
        do_reset();
        load_tile(8'h24, 8'hE4, 2'd2, 8'hAA, 8'hF0);
        fetch(S_VBLANK, 8'h55, 2'd0);
        n_cmp++;
        if (nt_byte !== 8'h24) begin
            n_err++;
            $display("FAIL vblank_ignored: got nt=%h want 24", nt_byte);
        end
        fetch(S_SLEEP, 8'h55, 2'd0);
        fetch(S_IDLE, 8'h55, 2'd0);
        fetch(3'b111, 8'h55, 2'd0);
        bg_state = S_MSB; step();
        bg_state = S_NT;  step();
        shift_n(8);
        shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (bg_pixel !== exp_tile[i]) begin
                n_err++;
                $display("FAIL ignored_pixel[%0d]: got %h want %h", i, bg_pixel, exp_tile[i]);
            end
        end
        // reset in BG_MSB with competing strobes, then released into NT
        bg_state = S_MSB; shift_en = 1'b0; step();
        rst = 1'b1; shift_en = 1'b1; data_valid = 1'b1; bg_state = S_NT; vram_data = 8'h77;
        step();
        rst = 1'b0; shift_en = 1'b0; data_valid = 1'b0;
        n_cmp++;
        if ({nt_byte, bg_pixel, bg_opaque, pixel_valid} !== 14'h0) begin
            n_err++;
            $display("FAIL rst_priority: got nt=%h pix=%h opq=%b val=%b want all 0",
                     nt_byte, bg_pixel, bg_opaque, pixel_valid);
        end
        step();
        n_cmp++;
        if ({nt_byte, bg_pixel, bg_opaque, pixel_valid} !== 14'h0) begin
            n_err++;
            $display("FAIL rst_release_nt: got nt=%h pix=%h opq=%b val=%b want all 0",
                     nt_byte, bg_pixel, bg_opaque, pixel_valid);
        end
        shift_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++;
            if (bg_pixel !== 4'h0 || bg_opaque !== 1'b0) begin
                n_err++;
                $display("FAIL post_rst_pixel[%0d]: got pix=%h opq=%b want 0 0", i, bg_pixel, bg_opaque);
            end
        end
        shift_en = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            bg_state   = 3'($urandom_range(0, 7));
            data_valid = ($urandom_range(0, 2) == 0);
            vram_data  = 8'($urandom);
            at_quad    = 2'($urandom_range(0, 3));
            shift_en   = ($urandom_range(0, 1) == 1);
            fine_x     = 3'($urandom_range(0, 7));
            pixel_x    = 8'($urandom_range(0, 20));
            bg_enable  = ($urandom_range(0, 7) != 0);
            show_left8 = ($urandom_range(0, 1) == 1);
            step();
            n_cmp++;
            if (nt_byte !== m_nt || bg_pixel !== m_pix || bg_opaque !== m_opq || pixel_valid !== m_val) begin
                n_err++;
                $display("FAIL random[%0d]: got nt=%h pix=%h opq=%b val=%b want nt=%h pix=%h opq=%b val=%b",
                         i, nt_byte, bg_pixel, bg_opaque, pixel_valid, m_nt, m_pix, m_opq, m_val);
            end
        end
        rst = 1'b0; data_valid = 1'b0; shift_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tile_decode();
        test_fine_scroll();
        test_clipping();
        test_shift_reload();
        test_ignored_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
